// File: rtl/wishbone_master_row_writer_pkg.sv
// Bus-width and address-tag definitions shared by the host-side master and the core's slave port.
// The row-to-word helper fixes the order in which words are sent (most significant first).
package wishbone_master_row_writer_pkg;

    localparam int WB_WIDTH     = 32;
    localparam int MCU_TAG_SIZE = 2;
    localparam int ROW_WIDTH    = 96;

    localparam logic [MCU_TAG_SIZE-1:0] TAG_WBS_INSTRUCTION_ADDRESS_TYPE = 2'b10;
    localparam logic [MCU_TAG_SIZE-1:0] TAG_WBS_DATA_ADDRESS_TYPE        = 2'b01;

    function automatic logic [WB_WIDTH-1:0] row_word(input logic [ROW_WIDTH-1:0] row,
                                                     input logic [1:0] k);
        case (k)
            2'd0:    return row[95:64];
            2'd1:    return row[63:32];
            default: return row[31:0];
        endcase
    endfunction

endpackage

// File: rtl/wishbone_master_row_writer_watchdog.sv
// ACK watchdog: 4-bit counter with clear/increment.
// tc_o flags the last cycle in which an ACK is still accepted.
module wb_ack_watchdog #(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic tc_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (incr_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Strobe phase spans TIMEOUT cycles; ACK in the final one still counts.
    assign tc_o = (count_q == TIMEOUT - 4'd1);

endmodule

// File: rtl/wishbone_master_row_writer.sv
// Wishbone master that writes one data row (3 words) or one instruction (2 words) into the core,
// then issues the commit cycle (MST_O=1, CYC_O=0). Every output is registered from the next state.
module wishbone_master_row_writer
    import wishbone_master_row_writer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    iStart,
    input  logic                    iIsInstruction,
    input  logic [15:0]             iAddress,
    input  logic [95:0]             iDataRow,
    output logic                    oBusy,
    output logic                    oDone,
    output logic                    oError,
    output logic                    CYC_O,
    output logic                    STB_O,
    output logic                    WE_O,
    output logic                    MST_O,
    output logic [WB_WIDTH-1:0]     ADR_O,
    output logic [MCU_TAG_SIZE-1:0] TGA_O,
    output logic [WB_WIDTH-1:0]     DAT_O,
    input  logic                    ACK_I
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CYC_UP, S_STROBE, S_GAP, S_COMMIT, S_FINISH, S_ABORT
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic                    is_instr_q;
    logic [ROW_WIDTH-1:0]    row_q;
    logic                    accept;
    logic                    last_word;
    logic                    wd_clear, wd_incr, wd_tc;

    logic                    busy_d, done_d, error_d, cyc_d, stb_d, we_d, mst_d;
    logic [WB_WIDTH-1:0]     adr_d, dat_d;
    logic [MCU_TAG_SIZE-1:0] tga_d;

    assign accept    = (state_q == S_IDLE) && iStart;
    assign last_word = is_instr_q ? (k_q == 2'd1) : (k_q == 2'd2);
    assign wd_clear  = (state_d == S_STROBE) && (state_q != S_STROBE);
    assign wd_incr   = (state_q == S_STROBE) && !ACK_I;

    wb_ack_watchdog #(
        .TIMEOUT (4'(ACK_TIMEOUT))
    ) u_watchdog (
        .clk_i   (CLK_I),
        .rst_n_i (RST_I),
        .clear_i (wd_clear),
        .incr_i  (wd_incr),
        .tc_o    (wd_tc)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= S_IDLE;
            k_q        <= 2'd0;
            is_instr_q <= 1'b0;
            row_q      <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                is_instr_q <= iIsInstruction;
                row_q      <= iDataRow;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_SETUP;
                    k_d     = 2'd0;
                end
            end
            S_SETUP:  state_d = S_CYC_UP;
            S_CYC_UP: state_d = S_STROBE;
            S_STROBE: begin
                if (ACK_I) begin
                    state_d = S_GAP;
                end else if (wd_tc) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP: begin
                if (last_word) begin
                    state_d = S_COMMIT;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = S_STROBE;
                end
            end
            S_COMMIT: state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each is a plain flop.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = 1'b0;
        error_d = 1'b0;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        mst_d   = 1'b0;
        adr_d   = ADR_O;
        tga_d   = TGA_O;
        dat_d   = DAT_O;
        if (accept) begin
            adr_d = {16'b0, iAddress};
            tga_d = iIsInstruction ? TAG_WBS_INSTRUCTION_ADDRESS_TYPE : TAG_WBS_DATA_ADDRESS_TYPE;
        end
        case (state_d)
            S_CYC_UP, S_GAP: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                mst_d = 1'b1;
            end
            S_STROBE: begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                we_d  = 1'b1;
                mst_d = 1'b1;
                dat_d = row_word(row_q, k_d);
            end
            S_COMMIT: begin
                we_d  = 1'b1;
                mst_d = 1'b1;
            end
            S_FINISH: done_d  = 1'b1;
            S_ABORT:  error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oError <= 1'b0;
            CYC_O  <= 1'b0;
            STB_O  <= 1'b0;
            WE_O   <= 1'b0;
            MST_O  <= 1'b0;
            ADR_O  <= '0;
            TGA_O  <= '0;
            DAT_O  <= '0;
        end else begin
            oBusy  <= busy_d;
            oDone  <= done_d;
            oError <= error_d;
            CYC_O  <= cyc_d;
            STB_O  <= stb_d;
            WE_O   <= we_d;
            MST_O  <= mst_d;
            ADR_O  <= adr_d;
            TGA_O  <= tga_d;
            DAT_O  <= dat_d;
        end
    end

endmodule

// File: tb/tb_wishbone_master_row_writer.sv
// Bench for wishbone_master_row_writer: directed and random transfers against a slave with
// programmable per-word ACK delay; expected timing comes from a cycle-cost model of the protocol.
module tb_wishbone_master_row_writer;

    localparam int TIMEOUT = 15;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        iStart = 1'b0;
    logic        iIsInstruction = 1'b0;
    logic [15:0] iAddress = '0;
    logic [95:0] iDataRow = '0;
    logic        oBusy, oDone, oError;
    logic        CYC_O, STB_O, WE_O, MST_O;
    logic [31:0] ADR_O, DAT_O;
    logic [1:0]  TGA_O;
    logic        ACK_I;

    int checks = 0;
    int errors = 0;

    // Slave: ACK d cycles after STB rises for word w (d=0 means never).
    int   dly [4];
    logic slv_ack;
    logic force_ack = 1'b0;
    int   slv_word;
    int   slv_cnt;

    assign ACK_I = slv_ack | force_ack;

    wishbone_master_row_writer #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .CLK_I          (CLK_I),
        .RST_I          (RST_I),
        .iStart         (iStart),
        .iIsInstruction (iIsInstruction),
        .iAddress       (iAddress),
        .iDataRow       (iDataRow),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .oError         (oError),
        .CYC_O          (CYC_O),
        .STB_O          (STB_O),
        .WE_O           (WE_O),
        .MST_O          (MST_O),
        .ADR_O          (ADR_O),
        .TGA_O          (TGA_O),
        .DAT_O          (DAT_O),
        .ACK_I          (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I || !CYC_O) begin
            slv_ack  <= 1'b0;
            slv_word <= 0;
            slv_cnt  <= 0;
        end else if (slv_ack) begin
            slv_ack  <= 1'b0;
            slv_word <= slv_word + 1;
            slv_cnt  <= 0;
        end else if (STB_O) begin
            slv_cnt <= slv_cnt + 1;
            if (dly[slv_word] != 0 && slv_cnt + 1 == dly[slv_word]) slv_ack <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [95:0] row, input int k);
        logic [95:0] r;
        r = row << (32 * k);
        return r[95:64];
    endfunction

    // Starts at posedge+1 (cycle 0) and returns at posedge+1 of cycle end+extra+1.
    task automatic run_transfer(input bit instr, input logic [15:0] addr, input logic [95:0] row,
                                input int d0, input int d1, input int d2,
                                input bit spur, input int extra);
        int ds [3];
        int n, t, abort_w, commit_c, done_c, err_c, end_c, exp_stb;
        int stb_cnt, commit_cnt, commit_first, done_cnt, done_first, err_cnt, err_first;
        int busy_cnt, busy_first, bad_we, bad_adr, bad_tga;
        logic [31:0] dat_seen [4];
        logic stb_prev;

        ds[0] = d0; ds[1] = d1; ds[2] = d2;
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = 0;

        // Model: SETUP@1, CYC_UP@2, first STB@3; a word ACKed after d cycles costs d+2 cycles.
        n = instr ? 2 : 3;
        t = 3;
        abort_w = -1;
        for (int w = 0; w < n; w++) begin
            if (ds[w] >= 1 && ds[w] <= TIMEOUT - 1) begin
                t += ds[w] + 2;
            end else begin
                abort_w = w;
                break;
            end
        end
        commit_c = -1; done_c = -1; err_c = -1;
        if (abort_w >= 0) begin
            err_c   = t + TIMEOUT;
            end_c   = err_c;
            exp_stb = abort_w + 1;
        end else begin
            commit_c = t;
            done_c   = t + 1;
            end_c    = done_c;
            exp_stb  = n;
        end

        stb_cnt = 0; commit_cnt = 0; commit_first = -1; done_cnt = 0; done_first = -1;
        err_cnt = 0; err_first = -1; busy_cnt = 0; busy_first = -1;
        bad_we = 0; bad_adr = 0; bad_tga = 0;
        stb_prev = 1'b0;
        for (int i = 0; i < 4; i++) dat_seen[i] = '0;

        iIsInstruction = instr;
        iAddress       = addr;
        iDataRow       = row;
        iStart         = 1'b1;

        for (int c = 0; c <= end_c + extra; c++) begin
            @(negedge CLK_I);
            if (STB_O && !stb_prev) begin
                if (stb_cnt < 4) dat_seen[stb_cnt] = DAT_O;
                stb_cnt++;
                if (!WE_O || !CYC_O || !MST_O) bad_we++;
                if (ADR_O !== {16'b0, addr}) bad_adr++;
                if (TGA_O !== (instr ? 2'b10 : 2'b01)) bad_tga++;
            end
            stb_prev = STB_O;
            if (MST_O && !CYC_O) begin
                commit_cnt++;
                if (commit_first < 0) commit_first = c;
                if (!WE_O) bad_we++;
                if (ADR_O !== {16'b0, addr}) bad_adr++;
            end
            if (oDone) begin
                done_cnt++;
                if (done_first < 0) done_first = c;
            end
            if (oError) begin
                err_cnt++;
                if (err_first < 0) err_first = c;
            end
            if (oBusy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
            end
            @(posedge CLK_I);
            #1;
            iStart    = spur && (c + 1 == 4);
            force_ack = spur && (c + 1 == 1);
            if (c == 0) begin
                iIsInstruction = ~instr;
                iAddress       = ~addr;
                iDataRow       = ~row;
            end
        end
        iStart    = 1'b0;
        force_ack = 1'b0;

        check("stb_count", 96'(stb_cnt), 96'(exp_stb));
        for (int k = 0; k < exp_stb && k < 3; k++)
            check($sformatf("dat_word%0d", k), 96'(dat_seen[k]), 96'(word_of(row, k)));
        check("bus_ctrl_during_stb", 96'(bad_we), 96'(0));
        check("adr_o", 96'(bad_adr), 96'(0));
        check("tga_o", 96'(bad_tga), 96'(0));
        check("commit_count", 96'(commit_cnt), 96'(abort_w >= 0 ? 0 : 1));
        check("done_count", 96'(done_cnt), 96'(abort_w >= 0 ? 0 : 1));
        check("error_count", 96'(err_cnt), 96'(abort_w >= 0 ? 1 : 0));
        if (abort_w < 0) begin
            check("commit_cycle", 96'(commit_first), 96'(commit_c));
            check("done_cycle", 96'(done_first), 96'(done_c));
        end else begin
            check("error_cycle", 96'(err_first), 96'(err_c));
        end
        check("busy_first", 96'(busy_first), 96'(1));
        check("busy_cycles", 96'(busy_cnt), 96'(end_c));

        $display("xfer instr=%0b adr=%h row=%h dly=%0d/%0d/%0d spur=%0b -> stb=%0d done@%0d err@%0d",
                 instr, addr, row, d0, d1, d2, spur, stb_cnt, done_first, err_first);
    endtask

    initial begin
        logic [95:0] rrow;
        logic [15:0] raddr;
        bit          rinstr;
        int          rd [3];
        int          nw, ok;

        for (int i = 0; i < 4; i++) dly[i] = 1;

        repeat (2) @(posedge CLK_I);
        #1;
        check("reset_outputs",
              96'({CYC_O, STB_O, WE_O, MST_O, oBusy, oDone, oError, TGA_O, ADR_O, DAT_O}), 96'(0));
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;

        // Directed: data row, instruction, late ACK, back-to-back restart
        run_transfer(1'b0, 16'h0012, 96'hAAAA0001_BBBB0002_CCCC0003, 1, 1, 1, 1'b0, 2);
        run_transfer(1'b1, 16'h0100, 96'h11112222_33334444_55556666, 1, 1, 1, 1'b0, 2);
        run_transfer(1'b0, 16'h0034, 96'h01234567_89ABCDEF_DEADBEEF, 6, 1, 1, 1'b0, 0);
        run_transfer(1'b1, 16'h0035, 96'hCAFEF00D_0BADC0DE_12345678, 1, 1, 1, 1'b0, 2);
        // Watchdog boundary: last accepted ACK, ACK one cycle too late, ACK never
        run_transfer(1'b0, 16'h0040, 96'h00000001_00000002_00000003, 14, 1, 1, 1'b0, 2);
        run_transfer(1'b0, 16'h0041, 96'h00000004_00000005_00000006, 1, 15, 1, 1'b0, 3);
        run_transfer(1'b0, 16'h0042, 96'h00000007_00000008_00000009, 1, 0, 1, 1'b0, 3);
        // Spurious iStart at cycle 4 and ACK during SETUP
        run_transfer(1'b0, 16'h0050, 96'hFEEDFACE_A5A5A5A5_5A5A5A5A, 1, 1, 1, 1'b1, 3);

        // Reset during the word1 strobe (cycle 6)
        dly[0] = 1; dly[1] = 1; dly[2] = 1;
        iIsInstruction = 1'b0;
        iAddress       = 16'h0077;
        iDataRow       = 96'h77770000_77771111_77772222;
        iStart         = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK_I);
            #1;
            iStart = 1'b0;
        end
        check("pre_reset_stb", 96'({CYC_O, STB_O, MST_O}), 96'(3'b111));
        #2;
        RST_I = 1'b0;
        #1;
        check("async_reset_drop", 96'({CYC_O, STB_O, WE_O, MST_O, oBusy}), 96'(0));
        ok = 0;
        repeat (3) begin
            @(negedge CLK_I);
            if (oDone || oError || CYC_O) ok++;
        end
        check("no_done_in_reset", 96'(ok), 96'(0));
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        run_transfer(1'b0, 16'h0078, 96'h88880000_88881111_88882222, 1, 1, 1, 1'b0, 2);

        // Random transfers
        for (int r = 0; r < 10; r++) begin
            rinstr = 1'($urandom_range(0, 1));
            raddr  = 16'($urandom);
            rrow   = {$urandom, $urandom, $urandom};
            nw     = rinstr ? 2 : 3;
            for (int w = 0; w < 3; w++) rd[w] = $urandom_range(1, 14);
            if ($urandom_range(0, 3) == 0) rd[$urandom_range(0, nw - 1)] = 0;
            run_transfer(rinstr, raddr, rrow, rd[0], rd[1], rd[2], 1'b0, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_master_row_writer.md
# wishbone_master_row_writer

Host-side Wishbone master that transfers one data row (3 × 32-bit words) or one instruction (2 × 32-bit words) into the Theia core's Wishbone slave write port. It sits between the host/DMA request logic and the core bus. It sequences CYC/STB/ACK per word, then issues the commit cycle that makes the slave write its data or instruction memory. It has an ACK watchdog that aborts a hung transfer.

## Interface
Parameters:
- `ACK_TIMEOUT`, 15: max cycles waiting for ACK_I per word before abort (4-bit counter).

Ports:
- `CLK_I` in 1: clock.
- `RST_I` in 1: reset, asynchronous, active-low.
- `iStart` in 1: request pulse; sampled only in IDLE.
- `iIsInstruction` in 1: 1 = instruction (2 words, tag 2'b10); 0 = data row (3 words, tag 2'b01).
- `iAddress` in 16: destination row/instruction address.
- `iDataRow` in 96: payload; word0 = [95:64], word1 = [63:32], word2 = [31:0].
- `oBusy` out 1: high from accept until return to IDLE.
- `oDone` out 1: one-cycle pulse, commit completed.
- `oError` out 1: one-cycle pulse, ACK timeout abort.
- `CYC_O`, `STB_O`, `WE_O`, `MST_O` out 1 each: Wishbone cycle, strobe, write enable, master-select.
- `ADR_O` out `WB_WIDTH` (32): {16'b0, latched address}.
- `TGA_O` out `MCU_TAG_SIZE` (2): address-type tag.
- `DAT_O` out `WB_WIDTH` (32): current word.
- `ACK_I` in 1: slave acknowledge.

## Operation
- On an accepted `iStart`, the block latches iAddress, iIsInstruction and iDataRow. The word count N is 2 for an instruction and 3 for data.
- FSM states:
  - IDLE: all bus outputs 0. When iStart=1, go to SETUP.
  - SETUP: drive ADR_O and TGA_O with CYC_O=0, so they are stable before the CYC rising edge. Next state CYC_UP.
  - CYC_UP: CYC_O=1, WE_O=1, MST_O=1, STB_O=0. Next state STROBE.
  - STROBE: STB_O=1 and DAT_O = word[k]. Wait for ACK_I.
    - On ACK_I=1, go to GAP.
    - If the watchdog reaches ACK_TIMEOUT, go to ABORT.
  - GAP: STB_O=0, which lets the slave drop ACK.
    - If k < N-1: increment k and go to STROBE.
    - Otherwise go to COMMIT.
  - COMMIT: CYC_O=0 with MST_O=1, WE_O=1, and ADR_O/TGA_O held, for exactly 1 cycle. This is the slave's write-enable condition. Next state FINISH.
  - FINISH: MST_O=0, WE_O=0, oDone=1 for 1 cycle. Next state IDLE.
  - ABORT: CYC_O, STB_O and WE_O drop together, MST_O=0, oError=1 for 1 cycle, no commit. Next state IDLE.
- Watchdog: clears on every entry to STROBE and increments each STROBE cycle with ACK_I=0. ACK arriving on the same cycle as the timeout is treated as an ACK, not an abort.
- ACK_I is ignored in every state except STROBE.
- iStart is ignored while oBusy=1; there is no queuing.
- ADR_O, TGA_O and DAT_O hold their values outside active states. Their reset value is 0.

## Timing
- All outputs reset asynchronously to 0; the FSM goes to IDLE and k to 0. A reset mid-transfer drops CYC_O/STB_O immediately, discards the transfer, and produces no oDone/oError.
- All outputs are registered, with no combinational path from ACK_I to any output.
- The slave ACKs 1 cycle after STB. With iStart at cycle 0:
  - SETUP is cycle 1, CYC_UP cycle 2, first STB cycle 3, first ACK cycle 4.
  - Each word costs 3 cycles (STB, ACK, GAP).
  - Data: COMMIT at cycle 12, oDone at 13. Instruction: COMMIT at 9, oDone at 10.
- oBusy is high from cycle 1 through the oDone/oError cycle inclusive.
- A new iStart is accepted on the cycle after oDone.

## Structure
- Shared package (aDefinitions.v): `WB_WIDTH`, `MCU_TAG_SIZE`, and the tag constants `TAG_WBS_INSTRUCTION_ADDRESS_TYPE`/`TAG_WBS_DATA_ADDRESS_TYPE` are moved there from the slave so both ends share one definition. FSM state encodings stay local.
- One sub-module, `wb_ack_watchdog`: a 4-bit counter with clear, increment and terminal-count output, on the same asynchronous active-low reset.

## Test plan
- Data write: iStart, iIsInstruction=0, iAddress=16'h0012, iDataRow=96'hAAAA0001_BBBB0002_CCCC0003 against a slave model with 1-cycle ACK.
  - DAT_O sequence AAAA0001, BBBB0002, CCCC0003; TGA_O=2'b01; ADR_O=32'h12.
  - COMMIT at cycle 12, oDone at 13.
- Instruction write: iIsInstruction=1, iAddress=16'h0100 → exactly 2 STB pulses (words [95:64], [63:32]), TGA_O=2'b10, oDone at cycle 10.
- ACK stall: slave withholds ACK indefinitely on word1 → ACK_TIMEOUT=15 cycles later, oError pulses, CYC_O/STB_O/WE_O drop, and no COMMIT cycle (MST_O=1 with CYC_O=0) ever occurs.
- Late ACK: ACK on word0 delayed 5 cycles → transfer completes normally, oDone 5 cycles later than nominal.
- Busy/spurious: iStart re-asserted at cycle 4, and ACK_I=1 forced during SETUP → both ignored, and only one transfer is observed.
- Reset mid-transfer: RST_I low during the word1 STB → CYC_O, STB_O, MST_O go 0 asynchronously, with no oDone; the next iStart after reset release runs a complete normal transfer.
